// File: rtl/clk_div_pkg.sv
`default_nettype none
// clk_div_pkg -- shared defaults and the channel-index width helper for clk_div_multi.
// rev 1.0

package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 0;

  // A single-channel build still needs a one-bit select port.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// clk_div_chan -- one divider channel: counter, active/shadow divisor, registered clock and tick.
// rev 1.0

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] C_DIV_RST = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_a;
  logic [CNT_W-1:0] div_s;
  logic             terminal;

  assign terminal = (cnt == div_a);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      div_a   <= C_DIV_RST;
      div_s   <= C_DIV_RST;
    end else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      if (pend) begin
        div_a <= div_s;
      end
    end else begin
      if (en) begin
        if (terminal) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          // Retune only on the falling terminal so each period starts fresh at the new rate.
          if (pend && clk_out) begin
            div_a <= div_s;
            pend  <= 1'b0;
          end
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        if (pend) begin
          div_a <= div_s;
          pend  <= 1'b0;
        end
      end
      // A write is only accepted while pend is clear, so it never collides with an apply above.
      if (wr) begin
        div_s <= wr_div;
        pend  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// clk_div_multi -- NCH independent glitch-free retunable clock dividers with a shared config port.
// rev 1.0

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NCH-1:0]           en_i,
  input  logic                     sync_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [ch_idx_w(NCH)-1:0] cfg_ch_i,
  input  logic [CNT_W-1:0]         cfg_div_i,
  output logic [NCH-1:0]           clk_o,
  output logic [NCH-1:0]           tick_o,
  output logic [NCH-1:0]           pend_o
);

  localparam int CH_W = ch_idx_w(NCH);

  logic           ch_free;
  logic [NCH-1:0] wr_sel;

  // Out-of-range channel numbers never match, leaving ch_free low.
  always_comb begin
    ch_free = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch_i == CH_W'(i)) begin
        ch_free = ~pend_o[i];
      end
    end
  end

  assign cfg_ready_o = ch_free & ~sync_i;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = cfg_valid_i & cfg_ready_o & (cfg_ch_i == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .en      (en_i[g]),
      .sync    (sync_i),
      .wr      (wr_sel[g]),
      .wr_div  (cfg_div_i),
      .clk_out (clk_o[g]),
      .tick    (tick_o[g]),
      .pend    (pend_o[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// tb_clk_div_multi -- directed plus randomized checks of clk_div_multi against a cycle-level spec model.
// rev 1.0

module tb_clk_div_multi;

  localparam int NCH     = 5;
  localparam int CNT_W   = 8;
  localparam int DIV_RST = 0;
  localparam int CH_W    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sync = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic [NCH-1:0]   clk_o;
  logic [NCH-1:0]   tick_o;
  logic [NCH-1:0]   pend_o;

  clk_div_multi #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .sync_i      (sync),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_div_i   (cfg_div),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .pend_o      (pend_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state, one entry per channel.
  int m_cnt  [NCH];
  int m_diva [NCH];
  int m_divs [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  int ticks, last_rise, last_fall, last_tog, nfall, rise_at, fall_at, nwait;
  int first_rise [NCH];
  logic prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int ch, input bit s);
    if (ch >= NCH || s) return 1'b0;
    return !m_pend[ch];
  endfunction

  function automatic logic [NCH-1:0] mv(input int sel);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      v[i] = (sel == 0) ? m_clk[i] : (sel == 1) ? m_tick[i] : m_pend[i];
    end
    return v;
  endfunction

  // Applies one rising edge of the specified behaviour to the reference state.
  task automatic model_edge();
    int wch;
    bit wr;
    wch = int'(cfg_ch);
    wr  = cfg_valid && m_ready(wch, sync);
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
        m_diva[i] = DIV_RST; m_divs[i] = DIV_RST;
      end
    end else if (sync) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        if (m_pend[i]) m_diva[i] = m_divs[i];
        m_pend[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (en[i]) begin
          if (m_cnt[i] == m_diva[i]) begin
            if (m_pend[i] && m_clk[i]) begin
              m_diva[i] = m_divs[i];
              m_pend[i] = 0;
            end
            m_cnt[i]  = 0;
            m_clk[i]  = !m_clk[i];
            m_tick[i] = 1;
          end else begin
            m_cnt[i]  = (m_cnt[i] + 1) % (1 << CNT_W);
            m_tick[i] = 0;
          end
        end else begin
          m_tick[i] = 0;
          if (m_pend[i]) begin
            m_diva[i] = m_divs[i];
            m_pend[i] = 0;
          end
        end
      end
      if (wr) begin
        m_divs[wch] = int'(cfg_div);
        m_pend[wch] = 1;
      end
    end
  endtask

  task automatic step();
    #1;
    if (rst_n) chk("cfg_ready", cfg_ready, m_ready(int'(cfg_ch), sync));
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("clk_o", clk_o, mv(0));
    chk("tick_o", tick_o, mv(1));
    chk("pend_o", pend_o, mv(2));
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_clk", clk_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_pend", pend_o, 0);
    rst_n  = 1'b1;
    cfg_ch = 3'd0;
    #1;
    chk("rdy_after_rst", cfg_ready, 1);

    // Channel 0 at divisor 0 toggles and ticks every cycle
    en = 5'b00001;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("div0_tick", tick_o[0], 1);
      chk("div0_clk", clk_o[0], k % 2);
      chk("div0_others", clk_o[NCH-1:1], 0);
    end

    // Write ch1 while disabled: pend clears on the next edge, then period 8
    cfg_ch = 3'd1; cfg_div = 8'd3; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("ch1_pend_set", pend_o[1], 1);
    step();
    chk("ch1_pend_clr", pend_o[1], 0);
    en = 5'b00011;
    ticks = 0; last_rise = -1; last_fall = -1;
    for (int k = 0; k < 24; k++) begin
      prev = clk_o[1];
      step();
      if (tick_o[1]) ticks++;
      if (!prev && clk_o[1]) begin
        if (last_rise >= 0) chk("ch1_period", cyc - last_rise, 8);
        last_rise = cyc;
      end
      if (prev && !clk_o[1]) last_fall = cyc;
    end
    chk("ch1_ticks", ticks, 6);

    // Retune ch1 to divisor 1 during its high phase
    nwait = 0;
    while (!clk_o[1] && nwait < 16) begin
      step();
      nwait++;
    end
    chk("ch1_rise_seen", clk_o[1], 1);
    last_tog = cyc;
    step();
    cfg_div = 8'd1; cfg_valid = 1'b1;
    #1;
    chk("retune_rdy", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("retune_pend", pend_o[1], 1);
    #1;
    chk("retune_rdy_busy", cfg_ready, 0);
    nfall = 0;
    for (int k = 0; k < 30; k++) begin
      prev = clk_o[1];
      step();
      if (prev != clk_o[1]) begin
        chk("retune_phase_min", (cyc - last_tog) >= 2, 1);
        last_tog = cyc;
      end
      if (prev && !clk_o[1]) begin
        nfall++;
        chk("retune_fall_gap", cyc - last_fall, (nfall == 1) ? 8 : 4);
        last_fall = cyc;
      end
    end
    chk("retune_pend_clr", pend_o[1], 0);

    // Divisors 0/1/2/5 free-running, then realign with sync
    cfg_ch = 3'd2; cfg_div = 8'd2; cfg_valid = 1'b1;
    step();
    cfg_ch = 3'd3; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    step();
    en = 5'b01111;
    nwait = 5 + $urandom_range(0, 6);
    for (int k = 0; k < nwait; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk", clk_o, 0);
    chk("sync_tick", tick_o, 0);
    for (int i = 0; i < NCH; i++) first_rise[i] = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        if (clk_o[i] && first_rise[i] < 0) first_rise[i] = k;
      end
    end
    chk("sync_rise_ch0", first_rise[0], 1);
    chk("sync_rise_ch1", first_rise[1], 2);
    chk("sync_rise_ch2", first_rise[2], 3);
    chk("sync_rise_ch3", first_rise[3], 6);

    // Out-of-range channel and sync both block writes
    cfg_ch = 3'd5; cfg_div = 8'd7; cfg_valid = 1'b1;
    #1;
    chk("oob_rdy", cfg_ready, 0);
    step();
    chk("oob_pend", pend_o, 0);
    cfg_ch = 3'd4; sync = 1'b1;
    #1;
    chk("sync_rdy", cfg_ready, 0);
    step();
    sync = 1'b0;
    chk("sync_wr_pend", pend_o, 0);

    // Maximum divisor: half period 256 cycles
    cfg_div = 8'hFF;
    step();
    cfg_valid = 1'b0;
    step();
    en = 5'b10000;
    rise_at = -1; fall_at = -1;
    for (int k = 1; k <= 520; k++) begin
      prev = clk_o[4];
      step();
      if (!prev && clk_o[4] && rise_at < 0) rise_at = k;
      if (prev && !clk_o[4] && fall_at < 0) fall_at = k;
    end
    chk("ff_rise", rise_at, 256);
    chk("ff_half", fall_at - rise_at, 256);

    // Randomized traffic checked cycle by cycle against the model
    for (int k = 0; k < 300; k++) begin
      en        = NCH'($urandom);
      sync      = ($urandom_range(0, 40) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, NCH));
      cfg_div   = CNT_W'($urandom_range(0, 6));
      step();
    end
    cfg_valid = 1'b0;

    // Reset mid-period with a pending divisor
    en = 5'b00010; sync = 1'b1;
    step();
    sync = 1'b0;
    cfg_ch = 3'd1; cfg_div = 8'd3; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("rst_pre_pend", pend_o[1], 1);
    rst_n = 1'b0;
    step();
    chk("rst_mid_clk", clk_o, 0);
    chk("rst_mid_tick", tick_o, 0);
    chk("rst_mid_pend", pend_o, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("post_rst_tick", tick_o[1], 1);
      chk("post_rst_clk", clk_o[1], k % 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
